// File: rtl/button_conditioner.sv
// Three-button front end for a stopwatch: synchronize, debounce, edge-detect,
// and drive the run/stop level. Define LONG_PRESS_EN to make a long start hold clear.
module button_conditioner_lane #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic raw,
   output logic stable,
   output logic rise
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          stable_d;

   // cnt never passes CNT_MAX: it either clears or commits there, so it cannot wrap
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync     <= '0;
         cnt      <= '0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
      end else if (en) begin
         sync     <= {sync[0], raw};
         stable_d <= stable;
         if (sync[1] == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            stable <= sync[1];
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign rise = stable & ~stable_d;
endmodule

module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 100000000
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic clear,
   input  logic quick,
   output logic run,
   output logic start_pulse,
   output logic clear_pulse,
   output logic quick_pulse,
   output logic debounce
);
   localparam int NUM_LANES = 3;

   logic                 rst_sync;
   logic [NUM_LANES-1:0] raw;
   logic [NUM_LANES-1:0] stable;
   logic [NUM_LANES-1:0] rise;
   logic                 long_hit;

   // One flop releases reset synchronously, so the first update lands on the
   // second rising clk after reset deasserts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync <= 1'b0;
      else        rst_sync <= 1'b1;
   end

   assign raw = {quick, clear, start};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      button_conditioner_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
         .clk    (clk),
         .reset  (reset),
         .en     (rst_sync),
         .raw    (raw[i]),
         .stable (stable[i]),
         .rise   (rise[i])
      );
   end

`ifdef LONG_PRESS_EN
   localparam int HW = $clog2(LONG_CYCLES + 1);
   logic [HW-1:0] hold_cnt;

   // Parks at LONG_CYCLES so the hit compare is true for a single cycle per press
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_cnt <= '0;
      end else if (rst_sync) begin
         if (!stable[0])                       hold_cnt <= '0;
         else if (hold_cnt != HW'(LONG_CYCLES)) hold_cnt <= hold_cnt + 1'b1;
      end
   end

   assign long_hit = stable[0] && (hold_cnt == HW'(LONG_CYCLES - 1));
`else
   assign long_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_pulse <= 1'b0;
         clear_pulse <= 1'b0;
         quick_pulse <= 1'b0;
         run         <= 1'b0;
      end else if (rst_sync) begin
         start_pulse <= rise[0];
         clear_pulse <= rise[1] | long_hit;
         quick_pulse <= rise[2];
         if (clear_pulse)      run <= 1'b0;
         else if (start_pulse) run <= ~run;
      end
   end

   assign debounce = stable[0];
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_button_conditioner;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0, clear = 1'b0, quick = 1'b0;
   logic run, start_pulse, clear_pulse, quick_pulse, debounce;
   int   pass = 0, total = 0;

   button_conditioner #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
      .clk(clk), .reset(reset), .start(start), .clear(clear), .quick(quick),
      .run(run), .start_pulse(start_pulse), .clear_pulse(clear_pulse),
      .quick_pulse(quick_pulse), .debounce(debounce)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic got, input logic want);
      total++;
      if (got !== want) $display("FAIL %s: got %0b want %0b", name, got, want);
      else pass++;
   endtask

   task automatic chk_cnt(input string name, input int got, input int want);
      total++;
      if (got !== want) $display("FAIL %s: got %0d want %0d", name, got, want);
      else pass++;
   endtask

   // advances n cycles, counting pulses seen
   task automatic settle(input int n, output int sp, output int cp, output int qp);
      sp = 0; cp = 0; qp = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         sp += int'(start_pulse); cp += int'(clear_pulse); qp += int'(quick_pulse);
      end
   endtask

   task automatic test_reset();
      #23;
      chk("rst_run", run, 1'b0);
      chk("rst_start_pulse", start_pulse, 1'b0);
      chk("rst_clear_pulse", clear_pulse, 1'b0);
      chk("rst_quick_pulse", quick_pulse, 1'b0);
      chk("rst_debounce", debounce, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      tick(); tick();
      chk("rst_release_run", run, 1'b0);
   endtask

   task automatic test_clean_press();
      int sp, cp, qp;
      start = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 10) start = 1'b0;
         chk($sformatf("clean_sp_c%0d", k), start_pulse, k == 7);
         chk($sformatf("clean_run_c%0d", k), run, k >= 8);
         chk($sformatf("clean_deb_c%0d", k), debounce, k >= 6);
      end
      settle(12, sp, cp, qp);
      chk_cnt("clean_release_pulses", sp + cp + qp, 0);
      chk("clean_release_deb", debounce, 1'b0);
   endtask

   task automatic test_glitch();
      int sp, cp, qp, deb_hi;
      deb_hi = 0;
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin tick(); deb_hi += int'(debounce); end
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin tick(); deb_hi += int'(debounce); end
      settle(8, sp, cp, qp);
      chk_cnt("glitch_pulses", sp, 0);
      chk_cnt("glitch_debounce", deb_hi, 0);
      chk("glitch_run", run, 1'b1);
   endtask

   task automatic test_bounce();
      int sp, cp, qp, bsp;
      bsp = 0;
      for (int k = 0; k < 12; k++) begin
         start = ((k % 4) < 2);
         tick();
         bsp += int'(start_pulse);
      end
      start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k < 7) bsp += int'(start_pulse);
         chk($sformatf("bounce_sp_c%0d", k), start_pulse, k == 7);
      end
      chk_cnt("bounce_early_pulses", bsp, 0);
      chk("bounce_run_toggled", run, 1'b0);
      start = 1'b0;
      settle(12, sp, cp, qp);
      chk_cnt("bounce_release_pulses", sp, 0);
   endtask

   task automatic test_quick();
      int sp, cp, qp;
      quick = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("quick_qp_c%0d", k), quick_pulse, k == 7);
         chk($sformatf("quick_run_c%0d", k), run, 1'b0);
      end
      quick = 1'b0;
      settle(12, sp, cp, qp);
      chk_cnt("quick_release_pulses", sp + cp + qp, 0);
   endtask

   task automatic test_back_to_back();
      int sp, cp, qp;
      start = 1'b1;
      for (int k = 1; k <= 10; k++) tick();
      chk("b2b_pre_run", run, 1'b1);
      start = 1'b0;
      settle(12, sp, cp, qp);
      start = 1'b1; clear = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("b2b_sp_c%0d", k), start_pulse, k == 7);
         chk($sformatf("b2b_cp_c%0d", k), clear_pulse, k == 7);
         chk($sformatf("b2b_run_c%0d", k), run, k < 8);
      end
      start = 1'b0; clear = 1'b0;
      settle(12, sp, cp, qp);
      chk_cnt("b2b_release_pulses", sp + cp, 0);
   endtask

   task automatic test_reset_mid();
      int sp, cp, qp;
      start = 1'b1;
      for (int k = 1; k <= 10; k++) tick();
      chk("rmid_pre_run", run, 1'b1);
      reset = 1'b0;
      #1;
      chk("rmid_async_run", run, 1'b0);
      chk("rmid_async_deb", debounce, 1'b0);
      tick(); tick(); tick();
      reset = 1'b1;
      settle(15, sp, cp, qp);
      chk_cnt("rmid_start_pulses", sp, 1);
      chk_cnt("rmid_clear_pulses", cp, 0);
      chk("rmid_run", run, 1'b1);
      start = 1'b0;
      settle(15, sp, cp, qp);
      chk_cnt("rmid_release_pulses", sp, 0);
   endtask

   task automatic test_clear();
      int sp, cp, qp;
      clear = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("clear_cp_c%0d", k), clear_pulse, k == 7);
         chk($sformatf("clear_run_c%0d", k), run, k < 8);
      end
      clear = 1'b0;
      settle(12, sp, cp, qp);
      chk_cnt("clear_release_pulses", cp, 0);
   endtask

   task automatic test_long_press();
      int sp, cp, qp, tsp, tcp;
      tsp = 0; tcp = 0;
      start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         tsp += int'(start_pulse); tcp += int'(clear_pulse);
         chk($sformatf("long_sp_c%0d", k), start_pulse, k == 7);
`ifdef LONG_PRESS_EN
         chk($sformatf("long_cp_c%0d", k), clear_pulse, k == 26);
         chk($sformatf("long_run_c%0d", k), run, (k >= 8) && (k < 27));
`else
         chk($sformatf("long_cp_c%0d", k), clear_pulse, 1'b0);
         chk($sformatf("long_run_c%0d", k), run, k >= 8);
`endif
      end
      chk_cnt("long_start_pulses", tsp, 1);
`ifdef LONG_PRESS_EN
      chk_cnt("long_clear_pulses", tcp, 1);
`else
      chk_cnt("long_clear_pulses", tcp, 0);
`endif
      start = 1'b0;
      settle(15, sp, cp, qp);
      chk_cnt("long_release_pulses", sp + cp, 0);
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_bounce();
      test_quick();
      test_back_to_back();
      test_reset_mid();
      test_clear();
      test_long_press();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the consecutive stable cycles needed to accept a new button level (5 ms at 100 MHz); legal range 2..2^20.
REQ-002 Parameter LONG_CYCLES, default 100000000, SHALL set the hold time for a long-press clear; it is used only when LONG_PRESS_EN is defined.
REQ-003 Port clk, input, 1: single system clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Ports start, clear, quick, input, 1 each: raw, asynchronous, bouncing push-button levels; 1 = pressed.
REQ-006 Port run, output, 1: stopwatch run/stop level.
REQ-007 Ports start_pulse, clear_pulse, quick_pulse, output, 1 each: single-cycle press events.
REQ-008 Port debounce, output, 1: debounced level of start.

Function
REQ-009 Each button SHALL pass through its own 2-flop synchronizer before any other use.
REQ-010 Each button SHALL have a debounce counter and a stable register. The counter clears whenever the synchronized level equals stable, and increments otherwise.
REQ-011 When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, stable SHALL take the synchronized level and the counter SHALL clear. A glitch shorter than DEBOUNCE_CYCLES SHALL never change stable.
REQ-012 Each pulse output SHALL be registered and high for exactly one cycle, in the cycle after its stable register rises 0->1. Releases SHALL produce no pulse.
REQ-013 Latency from a clean raw edge to its pulse SHALL be exactly DEBOUNCE_CYCLES+3 cycles: 2 for synchronization, DEBOUNCE_CYCLES to stabilize, 1 to register.
REQ-014 run SHALL toggle in the cycle after start_pulse.
REQ-015 run SHALL go to 0 in the cycle after clear_pulse.
REQ-016 If start_pulse and clear_pulse are high in the same cycle, clear SHALL win: run goes to 0 and does not toggle.
REQ-017 quick_pulse SHALL have no effect on run.
REQ-018 debounce SHALL equal the start stable register.
REQ-019 Holding a button for any length SHALL produce exactly one pulse. A new pulse requires a debounced release followed by a debounced press.
REQ-020 Debounce counters SHALL saturate and never wrap, whatever DEBOUNCE_CYCLES is set to.

Reset
REQ-021 While reset=0, all synchronizer flops, stable registers, counters, pulse outputs, run and debounce SHALL be 0, asynchronously.
REQ-022 Reset deassertion SHALL be synchronized internally; the first state update occurs on the second rising clk after reset rises.
REQ-023 A button held through reset release SHALL be treated as a fresh press: exactly one pulse after the REQ-013 latency, counted from the first active cycle.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count, with no pulse afterwards unless REQ-023 applies.

Configuration
REQ-025 With macro LONG_PRESS_EN defined, a hold counter SHALL count cycles while start's stable register is 1.
REQ-026 With LONG_PRESS_EN defined, when the hold counter reaches LONG_CYCLES-1, clear_pulse SHALL fire for one cycle and run SHALL then go to 0, once per press. The counter SHALL clear on release and on reset.
REQ-027 Without LONG_PRESS_EN, the hold counter and its logic SHALL be absent. clear_pulse SHALL come only from the clear button, and the LONG_CYCLES parameter SHALL be unused.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-028 Bench scenario, clean press: start 0->1 held 10 cycles -> start_pulse high for exactly cycle 7 after the edge; run 0->1 at cycle 8; debounce high from cycle 6.
REQ-029 Bench scenario, bounce: start toggles every 2 cycles for 12 cycles, then holds 1 -> no pulse during bouncing; exactly one start_pulse 7 cycles after the final rise.
REQ-030 Bench scenario, simultaneous press: with run=1, start and clear rise on the same cycle -> both pulses in the same cycle; run=0 afterwards, not toggled.
REQ-031 Bench scenario, reset mid-operation: run=1, reset=0 for 3 cycles while start is held -> run=0 immediately; one start_pulse after reset release per REQ-023; run=1.
REQ-032 Bench scenario, long press with LONG_PRESS_EN: start held 40 cycles -> start_pulse once (run=1), then clear_pulse once 20 cycles after debounce rises; run=0; no further pulses until release.
REQ-033 Bench scenario, long press without LONG_PRESS_EN: same stimulus as REQ-032 -> single start_pulse, no clear_pulse, run stays 1.
